pipe_stage_fifo: RTL and testbench
==================================

// Module: pipe_stage_fifo
// PURPOSE
//  Parametrised elastic pipeline buffer; successor to the fixed IF/ID, ID/EX, EX/MEM, MEM/WB latches.
//  Adds a DATA_W-wide payload, DEPTH entries of storage, valid/ready handshake, flush, occupancy and error flags.
//  Sits between two pipeline stages. Stall becomes back-pressure: out_ready=0.
//  A bubble is in_valid=0; bubbles are never stored.
// PARAMETERS
//  DATA_W     32  payload width in bits; all control bits of a stage are packed into it.
//  DEPTH      2   number of entries, 1..8; need not be a power of 2.
//  AFULL_LVL  1   almost_full asserts when count >= AFULL_LVL; range 1..DEPTH.
// PORTS
//  clk          in   1                 single clock; all state changes on its rising edge.
//  rst_b        in   1                 reset; asynchronous, active-high (1 = in reset).
//  flush        in   1                 synchronous discard of all stored entries.
//  in_valid     in   1                 upstream offers in_data.
//  in_ready     out  1                 buffer can accept this cycle.
//  in_data      in   DATA_W            payload from upstream.
//  out_valid    out  1                 out_data holds the oldest entry.
//  out_ready    in   1                 downstream consumes this cycle; 0 = stall.
//  out_data     out  DATA_W            oldest stored payload.
//  count        out  $clog2(DEPTH+1)   entries currently held.
//  almost_full  out  1                 count >= AFULL_LVL.
//  err_ovf      out  1                 sticky: push attempted while in_ready=0.
//  err_udf      out  1                 sticky: pop attempted while out_valid=0.
// BEHAVIOUR
//  - Reset (rst_b=1, async):
//    - count=0; wr/rd pointers=0; storage=0; out_data=0.
//    - out_valid=0; in_ready=1; almost_full=0; err_ovf=0; err_udf=0.
//    - Effect is immediate, mid-transfer included; partial transfers are lost.
//  - Definitions:
//    - push = in_valid & in_ready
//    - pop  = out_valid & out_ready
//  - Outputs are pure functions of registered state; no combinational path from any input to any output:
//    - in_ready  = (count != DEPTH)
//    - out_valid = (count != 0)
//    - out_data  = mem[rd_ptr]
//  - Latency: data pushed in cycle N is visible at out_data/out_valid in N+1 at the earliest.
//  - Throughput: 1 entry/cycle in steady state when DEPTH >= 2. DEPTH=1 gives at most 1 entry per 2 cycles.
//  - FIFO order is strict; the payload is never modified.
//  - Pointers wrap from DEPTH-1 to 0 (non-power-of-2 safe); they never use a modulo of 2^PTR_W.
//  - count next state:
//    - push only: +1
//    - pop only: -1
//    - push & pop: unchanged, both pointers advance
//    - neither: hold
//  - Full: in_ready=0, so push cannot occur. A pop in the same cycle does NOT raise in_ready that cycle.
//  - Empty: a pop cannot occur. push & out_ready in the same cycle just stores; out_valid rises next cycle.
//  - Flush has priority over push and pop in the same cycle:
//    - count=0 and pointers=0 next cycle.
//    - The concurrent push is dropped.
//    - Storage contents are left as-is; out_data is don't-care while out_valid=0.
//    - Sticky error flags are cleared.
//  - err_ovf sets on (in_valid & !in_ready); err_udf sets on (out_ready & !out_valid & UDF_CHECK).
//    - UDF_CHECK is a localparam, 0 by default, because stalls drive out_ready low but idle stages may hold it high.
//    - Both flags clear only on reset or flush.
//  - Storage is written only on push; only mem[wr_ptr] changes.
// STRUCTURE
//  - Shared package pipe_pkg:
//    - function ptr_w(depth) returning max(1,$clog2(depth)).
//    - typedef stage_ctrl_t: packed struct of the per-stage control bits (reg_write, mem_or_reg, pc_or_mem,
//      branch, jump, jump_register, is_unsigned), so stages size DATA_W as $bits(stage_ctrl_t)+payload.
//  - One sub-module: ring_ptr #(DEPTH).
//    - Ports: clk, rst_b, clr, inc, ptr.
//    - Wrapping counter with async reset; used twice (wr, rd).
//  - Remainder: storage array, count register, flag registers and output assigns in this module.
// TESTING
//  1. DEPTH=2: assert rst_b mid-stream with count=2.
//     -> out_valid=0, in_ready=1, count=0 in the same cycle, before the next edge.
//  2. DEPTH=2, out_ready=1: push 0xA1,0xA2,0xA3 on consecutive cycles.
//     -> out_data 0xA1,0xA2,0xA3 on cycles 1,2,3; count stays 1.
//  3. DEPTH=3, AFULL_LVL=2, out_ready=0: push 0x11,0x22,0x33,0x44.
//     -> almost_full at count=2; in_ready=0 at count=3; err_ovf=1 after the 0x44 attempt.
//     -> Then out_ready=1 drains 0x11,0x22,0x33 in order.
//  4. DEPTH=3: 10 push/pop interleaved cycles to force pointer wrap 2->0 twice.
//     -> Output sequence equals input sequence; count never exceeds 3.
//  5. DEPTH=4: count=3, then flush together with in_valid=1 (data 0x55) and out_ready=1.
//     -> Next cycle count=0, out_valid=0, err_ovf=0; 0x55 never appears at out_data.
//  6. Random valid/ready, 5000 cycles, DEPTH in {1,2,5}.
//     -> Scoreboard matches exactly; no output changes combinationally with inputs.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage buffers.
// Stages size their payload as $bits(stage_ctrl_t) + data bits.
package pipe_pkg;

  // Pointer width that stays at least one bit even for single-entry buffers.
  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic reg_write;
    logic mem_or_reg;
    logic pc_or_mem;
    logic branch;
    logic jump;
    logic jump_register;
    logic is_unsigned;
  } stage_ctrl_t;

  localparam int STAGE_CTRL_W = $bits(stage_ctrl_t);

endpackage

// File: rtl/ring_ptr.sv
// Wrapping index counter 0..DEPTH-1; wraps explicitly so non-power-of-2 depths work.
module ring_ptr
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge i_clk or posedge i_rst_b) begin
    if (i_rst_b) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/pipe_stage_fifo.sv
// Elastic buffer between two pipeline stages: valid/ready handshake, flush,
// occupancy and sticky overflow/underflow flags. All outputs come from registers.
module pipe_stage_fifo
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2,
  parameter int AFULL_LVL = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_b,
  input  logic                       i_flush,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [DATA_W-1:0]          i_in_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [DATA_W-1:0]          o_out_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full,
  output logic                       o_err_ovf,
  output logic                       o_err_udf
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);
  // Idle downstream stages may hold out_ready high, so underflow checking is off.
  localparam logic UDF_CHECK = 1'b0;

  logic [CNT_W-1:0]  r_count;
  logic              r_err_ovf;
  logic              r_err_udf;
  logic [PTR_W-1:0]  w_wr_ptr;
  logic [PTR_W-1:0]  w_rd_ptr;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_store;
  logic [DATA_W-1:0] w_mem [DEPTH];

  assign w_in_ready  = (r_count != FULL_CNT);
  assign w_out_valid = (r_count != '0);
  assign w_push      = i_in_valid & w_in_ready;
  assign w_pop       = w_out_valid & i_out_ready;
  assign w_store     = w_push & ~i_flush;

  ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst_b (i_rst_b),
    .i_clr   (i_flush),
    .i_inc   (w_push),
    .o_ptr   (w_wr_ptr)
  );

  ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst_b (i_rst_b),
    .i_clr   (i_flush),
    .i_inc   (w_pop),
    .o_ptr   (w_rd_ptr)
  );

  // One register per entry; only the entry under the write pointer is loaded.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] r_entry;

    always_ff @(posedge i_clk or posedge i_rst_b) begin
      if (i_rst_b) begin
        r_entry <= '0;
      end else if (w_store && (w_wr_ptr == PTR_W'(gi))) begin
        r_entry <= i_in_data;
      end
    end

    assign w_mem[gi] = r_entry;
  end

  always_ff @(posedge i_clk or posedge i_rst_b) begin
    if (i_rst_b) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst_b) begin
    if (i_rst_b) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else if (i_flush) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if (i_in_valid & ~w_in_ready) begin
        r_err_ovf <= 1'b1;
      end
      if (i_out_ready & ~w_out_valid & UDF_CHECK) begin
        r_err_udf <= 1'b1;
      end
    end
  end

  assign o_in_ready    = w_in_ready;
  assign o_out_valid   = w_out_valid;
  assign o_out_data    = w_mem[w_rd_ptr];
  assign o_count       = r_count;
  assign o_almost_full = (r_count >= AFULL_CNT);
  assign o_err_ovf     = r_err_ovf;
  assign o_err_udf     = r_err_udf;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: five instances (DEPTH 1..5) share one input stream;
// table vectors, directed corner cases and a queue scoreboard under random traffic.
module tb_pipe_stage_fifo;

  localparam int N  = 5;
  localparam int DW = 8;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;

  always #5 clk = ~clk;

  logic [N-1:0]         in_ready_v, out_valid_v, afull_v, ovf_v, udf_v;
  logic [N-1:0][DW-1:0] out_data_v;
  logic [N-1:0][2:0]    count_v;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int D  = gi + 1;
    localparam int AF = (gi + 2) / 2;
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] w_cnt;

    pipe_stage_fifo #(.DATA_W(DW), .DEPTH(D), .AFULL_LVL(AF)) u_dut (
      .i_clk         (clk),
      .i_rst_b       (rst),
      .i_flush       (flush),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready_v[gi]),
      .i_in_data     (in_data),
      .o_out_valid   (out_valid_v[gi]),
      .i_out_ready   (out_ready),
      .o_out_data    (out_data_v[gi]),
      .o_count       (w_cnt),
      .o_almost_full (afull_v[gi]),
      .o_err_ovf     (ovf_v[gi]),
      .o_err_udf     (udf_v[gi])
    );

    assign count_v[gi] = 3'(w_cnt);
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: one queue of expected payloads per instance.
  logic [DW-1:0] mq [N][$];
  bit            movf [N];

  function automatic int dep(input int k);
    return k + 1;
  endfunction

  function automatic int afl(input int k);
    return (k + 2) / 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      int c;
      c = mq[k].size();
      chk($sformatf("%s d%0d count", tag, k + 1), count_v[k], c);
      chk($sformatf("%s d%0d out_valid", tag, k + 1), out_valid_v[k], c != 0);
      chk($sformatf("%s d%0d in_ready", tag, k + 1), in_ready_v[k], c != dep(k));
      chk($sformatf("%s d%0d almost_full", tag, k + 1), afull_v[k], c >= afl(k));
      chk($sformatf("%s d%0d err_ovf", tag, k + 1), ovf_v[k], movf[k]);
      chk($sformatf("%s d%0d err_udf", tag, k + 1), udf_v[k], 1'b0);
      if (c != 0) chk($sformatf("%s d%0d out_data", tag, k + 1), out_data_v[k], mq[k][0]);
    end
  endtask

  // Called at a falling edge: drive, confirm outputs ignore the new inputs,
  // advance the model, clock once, compare at the next falling edge.
  task automatic run_cycle(input bit iv, input logic [DW-1:0] d, input bit orr,
                           input bit fl, input string tag);
    logic [79:0] snap;
    snap = {in_ready_v, out_valid_v, afull_v, ovf_v, udf_v, out_data_v, count_v};
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    flush     = fl;
    #1;
    chk({tag, " comb"}, {in_ready_v, out_valid_v, afull_v, ovf_v, udf_v, out_data_v, count_v}, snap);
    for (int k = 0; k < N; k++) begin
      int  c;
      bit  push, pop;
      c    = mq[k].size();
      push = iv && (c != dep(k));
      pop  = orr && (c != 0);
      if (fl) begin
        mq[k].delete();
        movf[k] = 1'b0;
      end else begin
        if (iv && (c == dep(k))) movf[k] = 1'b1;
        if (pop) void'(mq[k].pop_front());
        if (push) mq[k].push_back(d);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_data   = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  typedef struct {
    bit            rst_first;
    int            inst;
    bit            iv;
    logic [DW-1:0] d;
    bit            orr;
    bit            e_ir;
    bit            e_ov;
    logic [DW-1:0] e_data;
    int            e_cnt;
    bit            e_af;
    bit            e_ovf;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // DEPTH=2 streaming, then DEPTH=3 (AFULL_LVL=2) fill, overflow and drain.
    tbl[0]  = '{1'b1, 1, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 8'hA1, 1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA2, 1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3, 1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 3, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 3, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      int k;
      k = tbl[i].inst;
      if (tbl[i].rst_first) do_reset();
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].orr;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), in_ready_v[k], tbl[i].e_ir);
      chk($sformatf("vec%0d out_valid", i), out_valid_v[k], tbl[i].e_ov);
      chk($sformatf("vec%0d count", i), count_v[k], tbl[i].e_cnt);
      chk($sformatf("vec%0d almost_full", i), afull_v[k], tbl[i].e_af);
      chk($sformatf("vec%0d err_ovf", i), ovf_v[k], tbl[i].e_ovf);
      if (tbl[i].e_ov) chk($sformatf("vec%0d out_data", i), out_data_v[k], tbl[i].e_data);
    end

    // Asynchronous reset mid-stream with DEPTH=2 full.
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'hB1;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'hB2;
    @(posedge clk);
    @(negedge clk);
    chk("arst precount", count_v[1], 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst out_valid", out_valid_v[1], 1'b0);
    chk("arst in_ready", in_ready_v[1], 1'b1);
    chk("arst count", count_v[1], 0);
    chk("arst out_data", out_data_v[1], 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    model_reset();
    check_all("arst");

    // DEPTH=3 pointer wrap with interleaved push/pop.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, 8'h30 + 8'(i), (i % 4) != 0, 1'b0, $sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d count bound", i), count_v[2] <= 3'd3, 1'b1);
    end
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("wrapdrain%0d", i));

    // DEPTH=4 flush with concurrent push and pop.
    do_reset();
    run_cycle(1'b1, 8'h41, 1'b0, 1'b0, "fl_fill0");
    run_cycle(1'b1, 8'h42, 1'b0, 1'b0, "fl_fill1");
    run_cycle(1'b1, 8'h43, 1'b0, 1'b0, "fl_fill2");
    chk("flush precount", count_v[3], 3);
    run_cycle(1'b1, 8'h55, 1'b1, 1'b1, "flush");
    chk("flush count", count_v[3], 0);
    chk("flush out_valid", out_valid_v[3], 1'b0);
    chk("flush err_ovf", ovf_v[3], 1'b0);
    run_cycle(1'b0, 8'h00, 1'b1, 1'b0, "postflush0");
    run_cycle(1'b0, 8'h00, 1'b1, 1'b0, "postflush1");

    // Random traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      run_cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                $urandom_range(0, 63) == 0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
